// File: rtl/nibbler_sequencer.sv
// Fetch/execute control unit for the Nibbler core: sequences the Fetch register
// and decodes the latched opcode into single-cycle datapath strobes.
module nibbler_sequencer #(
  parameter int unsigned ROM_WAIT = 0,
  parameter int unsigned OP_W     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic [OP_W-1:0] instr,
  input  logic            carry,
  input  logic            zero,
  output logic            fetch_en,
  output logic            pc_inc,
  output logic            pc_load,
  output logic            acc_we,
  output logic            flags_we,
  output logic            ram_we,
  output logic            out_we,
  output logic            in_oe,
  output logic            imm_sel,
  output logic [2:0]      alu_op,
  output logic [1:0]      phase,
  output logic            instr_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10
  } state_t;

  localparam logic [2:0] WAIT_C  = 3'(ROM_WAIT);
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_PASS = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The state register doubles as the phase debug output.
  assign phase = state_q;

  // Strobes are decoded from the registered state so an asynchronous reset
  // removes them immediately. run gates only the FETCH wait; EXEC ignores it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fetch_en   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_we     = 1'b0;
    flags_we   = 1'b0;
    ram_we     = 1'b0;
    out_we     = 1'b0;
    in_oe      = 1'b0;
    imm_sel    = 1'b0;
    alu_op     = OP_ADD;
    instr_done = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (run) begin
          if (cnt_q == WAIT_C) begin
            fetch_en = 1'b1;
            cnt_d    = '0;
            state_d  = EXEC;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      EXEC: begin
        state_d    = FETCH;
        instr_done = 1'b1;
        pc_inc     = 1'b1;
        case (instr)
          4'h0: begin pc_load = carry;  pc_inc = ~carry; end
          4'h1: begin pc_load = ~carry; pc_inc = carry;  end
          4'h2: begin alu_op = OP_SUB;  imm_sel = 1'b1; flags_we = 1'b1; end
          4'h3: begin alu_op = OP_SUB;  flags_we = 1'b1; end
          4'h4: begin alu_op = OP_PASS; imm_sel = 1'b1; acc_we = 1'b1; end
          4'h5: begin alu_op = OP_PASS; in_oe = 1'b1;   acc_we = 1'b1; end
          4'h6: begin alu_op = OP_PASS; acc_we = 1'b1; end
          4'h7: ram_we = 1'b1;
          4'h8: begin alu_op = OP_ADD;  imm_sel = 1'b1; acc_we = 1'b1; flags_we = 1'b1; end
          4'h9: begin alu_op = OP_ADD;  acc_we = 1'b1;  flags_we = 1'b1; end
          4'hA: begin pc_load = 1'b1;   pc_inc = 1'b0; end
          4'hB: out_we = 1'b1;
          4'hC: begin alu_op = OP_NAND; imm_sel = 1'b1; acc_we = 1'b1; flags_we = 1'b1; end
          4'hD: begin alu_op = OP_NAND; acc_we = 1'b1;  flags_we = 1'b1; end
          4'hE: begin pc_load = zero;   pc_inc = ~zero; end
          default: begin pc_load = ~zero; pc_inc = zero; end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibbler_sequencer.sv
// Bench for nibbler_sequencer: two instances (ROM_WAIT 0 and 2) share random
// stimulus and are scored every cycle against a countdown reference model.
module tb_nibbler_sequencer;

  typedef struct packed {
    logic       fetch_en;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_we;
    logic       flags_we;
    logic       ram_we;
    logic       out_we;
    logic       in_oe;
    logic       imm_sel;
    logic [2:0] alu_op;
    logic [1:0] phase;
    logic       instr_done;
  } out_t;

  localparam int W = $bits(out_t);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       run = 1'b1;
  logic [3:0] instr = 4'h0;
  logic       carry = 1'b0;
  logic       zero = 1'b0;

  out_t act [2];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  always #5 clk = ~clk;

  nibbler_sequencer #(.ROM_WAIT(0), .OP_W(4)) dut0 (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .carry(carry), .zero(zero),
    .fetch_en(act[0].fetch_en), .pc_inc(act[0].pc_inc), .pc_load(act[0].pc_load),
    .acc_we(act[0].acc_we), .flags_we(act[0].flags_we), .ram_we(act[0].ram_we),
    .out_we(act[0].out_we), .in_oe(act[0].in_oe), .imm_sel(act[0].imm_sel),
    .alu_op(act[0].alu_op), .phase(act[0].phase), .instr_done(act[0].instr_done)
  );

  nibbler_sequencer #(.ROM_WAIT(2), .OP_W(4)) dut1 (
    .clk(clk), .reset(reset), .run(run), .instr(instr), .carry(carry), .zero(zero),
    .fetch_en(act[1].fetch_en), .pc_inc(act[1].pc_inc), .pc_load(act[1].pc_load),
    .acc_we(act[1].acc_we), .flags_we(act[1].flags_we), .ram_we(act[1].ram_we),
    .out_we(act[1].out_we), .in_oe(act[1].in_oe), .imm_sel(act[1].imm_sel),
    .alu_op(act[1].alu_op), .phase(act[1].phase), .instr_done(act[1].instr_done)
  );

  // Expected EXEC-cycle outputs straight from the opcode table.
  function automatic out_t exec_expect(input logic [3:0] op, input logic c, input logic z);
    out_t o;
    bit   is_br;
    bit   taken;
    o = '0;
    o.phase = 2'b10;
    o.instr_done = 1'b1;
    is_br = 1'b0;
    taken = 1'b0;
    case (op)
      4'h0: begin is_br = 1; taken = c;  end
      4'h1: begin is_br = 1; taken = !c; end
      4'h2: begin o.alu_op = 3'd1; o.imm_sel = 1; o.flags_we = 1; end
      4'h3: begin o.alu_op = 3'd1; o.flags_we = 1; end
      4'h4: begin o.alu_op = 3'd2; o.imm_sel = 1; o.acc_we = 1; end
      4'h5: begin o.alu_op = 3'd2; o.in_oe = 1; o.acc_we = 1; end
      4'h6: begin o.alu_op = 3'd2; o.acc_we = 1; end
      4'h7: o.ram_we = 1;
      4'h8: begin o.alu_op = 3'd0; o.imm_sel = 1; o.acc_we = 1; o.flags_we = 1; end
      4'h9: begin o.alu_op = 3'd0; o.acc_we = 1; o.flags_we = 1; end
      4'hA: begin is_br = 1; taken = 1; end
      4'hB: o.out_we = 1;
      4'hC: begin o.alu_op = 3'd3; o.imm_sel = 1; o.acc_we = 1; o.flags_we = 1; end
      4'hD: begin o.alu_op = 3'd3; o.acc_we = 1; o.flags_we = 1; end
      4'hE: begin is_br = 1; taken = z;  end
      default: begin is_br = 1; taken = !z; end
    endcase
    o.pc_load = is_br && taken;
    o.pc_inc  = !o.pc_load;
    return o;
  endfunction

  // Reference model: mode 0 idle, 1 fetch, 2 exec; need counts the run-high
  // FETCH cycles still required before the fetch strobe.
  int rw   [2] = '{0, 2};
  int mode [2] = '{0, 0};
  int need [2] = '{1, 3};

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      out_t e;
      e = '0;
      if (!reset) begin
        mode[k] = 0;
      end else begin
        case (mode[k])
          0: begin
            mode[k] = 1;
            need[k] = rw[k] + 1;
          end
          1: begin
            e.phase = 2'b01;
            if (run) begin
              if (need[k] == 1) begin
                e.fetch_en = 1'b1;
                mode[k] = 2;
              end else begin
                need[k] = need[k] - 1;
              end
            end
          end
          default: begin
            e = exec_expect(instr, carry, zero);
            mode[k] = 1;
            need[k] = rw[k] + 1;
          end
        endcase
      end
      if (k == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  end

  // Monitor: every cycle each instance presents a full output vector.
  always @(negedge clk) begin
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [W-1:0] e;
      n_checks++;
      if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
        n_fail++;
        $display("FAIL cycle_out dut%0d: actual %h, required an expected entry (queue empty)", k, act[k]);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        if (act[k] !== e) begin
          n_fail++;
          $display("FAIL cycle_out dut%0d t=%0t instr=%h c=%b z=%b run=%b: actual %h, required %h",
                   k, $time, instr, carry, zero, run, act[k], e);
        end
      end
    end
  end

  task automatic step_random(input int n, input int run_bias);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      instr = 4'($urandom_range(0, 15));
      carry = 1'($urandom_range(0, 1));
      zero  = 1'($urandom_range(0, 1));
      run   = ($urandom_range(0, 99) < run_bias);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b0;
    run   = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Every opcode with every flag combination, long enough to reach EXEC.
    for (int op = 0; op < 16; op++) begin
      for (int cz = 0; cz < 4; cz++) begin
        @(posedge clk); #1;
        instr = 4'(op);
        carry = cz[0];
        zero  = cz[1];
        run   = 1'b1;
        repeat (3) @(posedge clk);
      end
    end

    // Halt: run low for several cycles, then resume.
    @(posedge clk); #1 run = 1'b0;
    repeat (5) @(posedge clk);
    #1 run = 1'b1;
    repeat (6) @(posedge clk);

    step_random(300, 75);
    step_random(200, 40);

    // Asynchronous reset during an ADDM execute cycle.
    @(posedge clk); #1;
    instr = 4'h9; run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (act[0].instr_done) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL find_exec: actual no EXEC in 10 cycles, required EXEC");
    end
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (act[k] !== out_t'(0)) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: actual %h, required 0", k, act[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    step_random(100, 70);
    repeat (2) @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
